wb_pwm_capture: RTL and testbench

//  Wishbone B4 slave that measures incoming PWM signals: per channel it reports the

---
 rtl/wb_pwm_capture_pkg.sv | 27 ++
 rtl/wb_pwm_capture_if.sv | 17 +
 rtl/pwm_capture_channel.sv | 63 ++++++
 rtl/wb_pwm_capture.sv | 67 ++++++
 tb/tb_wb_pwm_capture.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pwm_capture_pkg.sv
// Shared register-map constants and helpers for the PWM capture peripheral.
// Word addresses: PERIOD/HIGH pairs per channel, then one STATUS word.
package wb_pwm_capture_pkg;

  localparam int PERIOD_STRIDE    = 2;
  localparam int STATUS_VALID_LSB = 0;
  localparam int STATUS_LEVEL_LSB = 16;
  localparam int ACK_LATENCY      = 1;

  typedef struct packed {
    logic        ack;
    logic [31:0] data;
  } wb_rsp_t;

  function automatic int period_addr(input int ch);
    return PERIOD_STRIDE * ch;
  endfunction

  function automatic int high_addr(input int ch);
    return PERIOD_STRIDE * ch + 1;
  endfunction

  function automatic int status_addr(input int pins);
    return PERIOD_STRIDE * pins;
  endfunction

endpackage

// File: rtl/wb_pwm_capture_if.sv
// Pipelined Wishbone B4 slave port of the PWM capture block (cyc implied by stb).
interface wb_pwm_capture_if #(
  parameter int WB_ADDR_BITS = 32
);
  logic                    i_wb_stb;
  logic                    i_wb_we;
  logic [WB_ADDR_BITS-1:0] i_wb_addr;
  logic [31:0]             i_wb_data;
  logic [31:0]             o_wb_data;
  logic                    o_wb_stall;
  logic                    o_wb_ack;

  modport slave  (input  i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
                  output o_wb_data, o_wb_stall, o_wb_ack);
  modport master (output i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
                  input  o_wb_data, o_wb_stall, o_wb_ack);
endinterface

// File: rtl/pwm_capture_channel.sv
// One capture channel: synchroniser, rising-edge detect, saturating period/high
// counters, arm/valid tracking and static-line timeout.
module pwm_capture_channel #(
  parameter int CNT_BITS = 16
) (
  input  logic                i_wb_clk,
  input  logic                i_wb_rst,
  input  logic                pwm,
  input  logic                clr_valid,
  output logic [CNT_BITS-1:0] period,
  output logic [CNT_BITS-1:0] high,
  output logic                level,
  output logic                valid
);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic [1:0]          sync;
  logic                prev;
  logic                armed;
  logic                rise;
  logic [CNT_BITS-1:0] per_cnt;
  logic [CNT_BITS-1:0] hi_cnt;

  assign level = sync[1];
  assign rise  = sync[1] & ~prev;

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      sync    <= '0;
      prev    <= 1'b0;
      armed   <= 1'b0;
      valid   <= 1'b0;
      per_cnt <= '0;
      hi_cnt  <= '0;
      period  <= '0;
      high    <= '0;
    end else begin
      sync <= {sync[0], pwm};
      prev <= sync[1];
      if (clr_valid) valid <= 1'b0;
      // a latch later in this block overrides a same-cycle clear
      if (rise) begin
        if (armed) begin
          period <= per_cnt;
          high   <= hi_cnt;
          valid  <= 1'b1;
        end
        per_cnt <= CNT_ONE;
        hi_cnt  <= CNT_ONE;
        armed   <= 1'b1;
      end else if (per_cnt == CNT_MAX) begin
        period <= CNT_MAX;
        high   <= level ? CNT_MAX : '0;
        valid  <= 1'b0;
        armed  <= 1'b0;
      end else begin
        per_cnt <= per_cnt + 1'b1;
        if (level && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_pwm_capture.sv
// Wishbone slave measuring PWM period and high time per channel between
// consecutive rising edges; channel instances plus decode, read mux and ack.
module wb_pwm_capture
  import wb_pwm_capture_pkg::*;
#(
  parameter int WB_ADDR_BITS = 32,
  parameter int PWM_PINS     = 1,
  parameter int CNT_BITS     = 16
) (
  input  logic                i_wb_clk,
  input  logic                i_wb_rst,
  wb_pwm_capture_if.slave     wb,
  input  logic [PWM_PINS-1:0] i_pwm_channel
);
  localparam logic [WB_ADDR_BITS-1:0] STATUS_ADDR = WB_ADDR_BITS'(status_addr(PWM_PINS));

  logic [PWM_PINS-1:0][CNT_BITS-1:0] period;
  logic [PWM_PINS-1:0][CNT_BITS-1:0] high;
  logic [PWM_PINS-1:0]               level;
  logic [PWM_PINS-1:0]               valid;
  logic [PWM_PINS-1:0]               clr_valid;
  logic                              status_wr;
  logic [31:0]                       rdata;
  wb_rsp_t                           rsp_q;

  assign status_wr = wb.i_wb_stb & wb.i_wb_we & (wb.i_wb_addr == STATUS_ADDR);
  assign clr_valid = {PWM_PINS{status_wr}} & wb.i_wb_data[PWM_PINS-1:0];

  for (genvar n = 0; n < PWM_PINS; n++) begin : g_ch
    pwm_capture_channel #(.CNT_BITS(CNT_BITS)) u_ch (
      .i_wb_clk  (i_wb_clk),
      .i_wb_rst  (i_wb_rst),
      .pwm       (i_pwm_channel[n]),
      .clr_valid (clr_valid[n]),
      .period    (period[n]),
      .high      (high[n]),
      .level     (level[n]),
      .valid     (valid[n])
    );
  end

  always_comb begin
    rdata = '0;
    if (wb.i_wb_addr == STATUS_ADDR) begin
      rdata[STATUS_VALID_LSB +: PWM_PINS] = valid;
      rdata[STATUS_LEVEL_LSB +: PWM_PINS] = level;
    end
    for (int n = 0; n < PWM_PINS; n++) begin
      if (wb.i_wb_addr == WB_ADDR_BITS'(period_addr(n))) rdata[CNT_BITS-1:0] = period[n];
      if (wb.i_wb_addr == WB_ADDR_BITS'(high_addr(n)))   rdata[CNT_BITS-1:0] = high[n];
    end
  end

  // every strobe is answered next cycle; data is forced to 0 between acks
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      rsp_q <= '0;
    end else begin
      rsp_q.ack  <= wb.i_wb_stb;
      rsp_q.data <= wb.i_wb_stb ? rdata : '0;
    end
  end

  assign wb.o_wb_ack   = rsp_q.ack;
  assign wb.o_wb_data  = rsp_q.data;
  assign wb.o_wb_stall = 1'b0;
endmodule

// File: tb/tb_wb_pwm_capture.sv
// Scoreboard bench for wb_pwm_capture: 2 channels, 8-bit counters, ch1 held low.
module tb_wb_pwm_capture;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gen_on = 1'b0;
  logic       gen_pwm = 1'b0;
  logic       man_pwm = 1'b0;
  logic       done = 1'b0;
  logic [1:0] pins;

  always #5 clk = ~clk;

  assign pins = {1'b0, gen_on ? gen_pwm : man_pwm};

  wb_pwm_capture_if #(.WB_ADDR_BITS(32)) wb ();

  wb_pwm_capture #(.WB_ADDR_BITS(32), .PWM_PINS(2), .CNT_BITS(8)) dut (
    .i_wb_clk      (clk),
    .i_wb_rst      (rst),
    .wb            (wb),
    .i_pwm_channel (pins)
  );

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    bit          chk;
  } sb_t;

  sb_t   exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;
  logic  exp_ack = 1'b0;
  sb_t   e;
  string nm;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ex, input logic [31:0] m,
                    input string n);
    wb.i_wb_stb  = 1'b1;
    wb.i_wb_we   = 1'b0;
    wb.i_wb_addr = a;
    wb.i_wb_data = '0;
    exp_q.push_back('{ex, m, 1'b1});
    name_q.push_back(n);
    tick();
    wb.i_wb_stb = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wb.i_wb_stb  = 1'b1;
    wb.i_wb_we   = 1'b1;
    wb.i_wb_addr = a;
    wb.i_wb_data = d;
    exp_q.push_back('{32'h0, 32'h0, 1'b0});
    name_q.push_back("wr");
    tick();
    wb.i_wb_stb = 1'b0;
    wb.i_wb_we  = 1'b0;
  endtask

  // free-running 3 high / 5 low source
  initial begin : gen
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (gen_on) begin
        gen_pwm = (ph < 3);
        ph = (ph == 7) ? 0 : ph + 1;
      end else begin
        gen_pwm = 1'b0;
        ph = 0;
      end
    end
  end

  initial begin : mon
    forever begin
      @(negedge clk);
      checks++;
      if (wb.o_wb_ack !== exp_ack) begin
        errors++;
        $display("FAIL ack_timing: ack=%b required %b at %0t", wb.o_wb_ack, exp_ack, $time);
      end
      if (wb.o_wb_ack !== 1'b1) begin
        checks++;
        if (wb.o_wb_data !== 32'h0) begin
          errors++;
          $display("FAIL idle_data: data=%h required 0 at %0t", wb.o_wb_data, $time);
        end
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: data=%h at %0t", wb.o_wb_data, $time);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.chk) begin
          checks++;
          if ((wb.o_wb_data & e.mask) !== (e.exp & e.mask)) begin
            errors++;
            $display("FAIL %s: got %h required %h (mask %h) at %0t",
                     nm, wb.o_wb_data, e.exp, e.mask, $time);
          end
        end
      end
      exp_ack = wb.i_wb_stb & ~rst;
      if (done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL sb_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin : stim
    wb.i_wb_stb  = 1'b0;
    wb.i_wb_we   = 1'b0;
    wb.i_wb_addr = '0;
    wb.i_wb_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    rd(0, 0, 32'hFFFF_FFFF, "rst_period0");
    rd(1, 0, 32'hFFFF_FFFF, "rst_high0");
    rd(4, 0, 32'hFFFF_FFFF, "rst_status");

    // single edge only arms
    man_pwm = 1'b1; repeat (3) tick();
    man_pwm = 1'b0; repeat (2) tick();
    rd(4, 0, 32'h1, "one_edge_valid");
    gen_on = 1'b1;
    repeat (40) tick();
    rd(0, 8, 32'hFFFF_FFFF, "run_period");
    rd(1, 3, 32'hFFFF_FFFF, "run_high");
    rd(4, 1, 32'h1, "run_valid");

    // static-high timeout; ch1 has been static low since reset
    gen_on  = 1'b0;
    man_pwm = 1'b1;
    repeat (300) tick();
    rd(0, 32'hFF, 32'hFFFF_FFFF, "to_period0");
    rd(1, 32'hFF, 32'hFFFF_FFFF, "to_high0");
    rd(2, 32'hFF, 32'hFFFF_FFFF, "to_period1");
    rd(3, 0, 32'hFFFF_FFFF, "to_high1");
    rd(4, 32'h0001_0000, 32'hFFFF_FFFF, "to_status");

    // resume: edge A arms, edge B (8 later) latches
    man_pwm = 1'b0; repeat (5) tick();
    man_pwm = 1'b1; repeat (3) tick();
    man_pwm = 1'b0; repeat (2) tick();
    rd(4, 0, 32'h1, "resume_one_edge");
    repeat (2) tick();
    man_pwm = 1'b1; repeat (3) tick();
    man_pwm = 1'b0; repeat (3) tick();
    rd(0, 8, 32'hFFFF_FFFF, "resume_period");
    rd(1, 3, 32'hFFFF_FFFF, "resume_high");
    rd(4, 1, 32'h1, "resume_valid");

    // W1C, then W1C on the exact latch cycle of edge C (11 after B)
    wr(4, 1);
    rd(4, 0, 32'h1, "w1c_clear");
    man_pwm = 1'b1; tick(); tick();
    wr(4, 1);
    man_pwm = 1'b0;
    rd(4, 1, 32'h1, "w1c_collide");

    // back-to-back strobes, RO writes and out-of-range addresses
    rd(0, 11, 32'hFFFF_FFFF, "b2b_period");
    wr(0, 32'hFF);
    rd(0, 11, 32'hFFFF_FFFF, "ro_period");
    wr(1, 0);
    rd(1, 3, 32'hFFFF_FFFF, "ro_high");
    rd(32'h40, 0, 32'hFFFF_FFFF, "oor_40");
    wr(32'h40, 32'hFFFF_FFFF);
    rd(5, 0, 32'hFFFF_FFFF, "oor_5");
    wr(4, 0);
    rd(4, 1, 32'h1, "w1c_zero");

    // reset mid-period with a strobe pending
    man_pwm = 1'b1; repeat (4) tick();
    man_pwm = 1'b0; repeat (2) tick();
    rst = 1'b1;
    wb.i_wb_stb  = 1'b1;
    wb.i_wb_addr = 0;
    tick();
    wb.i_wb_stb = 1'b0;
    tick();
    rst = 1'b0;
    rd(0, 0, 32'hFFFF_FFFF, "rst2_period0");
    rd(1, 0, 32'hFFFF_FFFF, "rst2_high0");
    rd(2, 0, 32'hFFFF_FFFF, "rst2_period1");
    rd(3, 0, 32'hFFFF_FFFF, "rst2_high1");
    rd(4, 0, 32'hFFFF_FFFF, "rst2_status");
    man_pwm = 1'b1; repeat (3) tick();
    man_pwm = 1'b0; repeat (4) tick();
    rd(4, 0, 32'h1, "rst2_one_edge");
    man_pwm = 1'b1; repeat (3) tick();
    man_pwm = 1'b0; repeat (3) tick();
    rd(0, 8, 32'hFFFF_FFFF, "rst2_period");
    rd(1, 3, 32'hFFFF_FFFF, "rst2_high");
    rd(4, 1, 32'h1, "rst2_valid");

    repeat (3) tick();
    done = 1'b1;
  end
endmodule
